// File: rtl/arb16_pkg.sv
// arb16_pkg: shared types and constants for the 16-way burst-locking arbiter
package arb16_pkg;
  localparam int NUM_REQ = 16;
  localparam int IDX_W = 4;
  localparam int DEFAULT_IDLE_TIMEOUT = 16;
  typedef enum logic {
    ST_IDLE,
    ST_OWNED
  } arb_state_e;
endpackage

// File: rtl/rr_pick16.sv
// rr_pick16: round-robin picker, first set bit of vec_i at or after start_i (wrapping)
//   vec_i   candidate request vector
//   start_i highest-priority index
//   found_o any bit set
//   idx_o   winning index
module rr_pick16
  import arb16_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   off;
  // rot[k] is the request k places after start_i; the 4-bit index add wraps 15 -> 0
  always_comb begin
    rot = '0;
    off = '0;
    for (int k = 0; k < NUM_REQ; k++) rot[k] = vec_i[start_i + IDX_W'(k)];
    for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) off = IDX_W'(k);
  end
  assign found_o = |vec_i;
  assign idx_o   = start_i + off;
endmodule

// File: rtl/mux16_arbiter.sv
// mux16_arbiter: round-robin burst-locking owner select for a 16-way mux with idle watchdog
//   clk, rst     clock, synchronous active-high reset
//   req, last    per-requester beat pending / final beat of burst
//   out_ready    downstream accepts the selected beat
//   sel, gnt     owner index and one-hot grant (registered)
//   out_valid    owner's beat valid; ack one-hot accept pulse (combinational)
//   busy         mux owned; timeout_err one-cycle forced-release pulse
module mux16_arbiter
  import arb16_pkg::*;
#(
  parameter int NUM_REQ      = 16,
  parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   sel,
  output logic [NUM_REQ-1:0] gnt,
  output logic               out_valid,
  output logic [NUM_REQ-1:0] ack,
  output logic               busy,
  output logic               timeout_err
);
  if (NUM_REQ != arb16_pkg::NUM_REQ) begin : g_bad_num_req
    $error("mux16_arbiter: NUM_REQ must be 16");
  end
  if (IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 255) begin : g_bad_timeout
    $error("mux16_arbiter: IDLE_TIMEOUT must be in 1..255");
  end

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d, ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d, tmo_q, tmo_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               owned, accept, timed_out, release_w, take, drop, found;
  logic [IDX_W-1:0]   pick_idx;

  // While idle sel_q always equals ptr_q, so sel_q + 1 is the search start in
  // both states and puts a releasing owner at lowest priority.
  rr_pick16 u_pick (
    .vec_i   (req),
    .start_i (sel_q + IDX_W'(1)),
    .found_o (found),
    .idx_o   (pick_idx)
  );

  assign owned     = state_q == ST_OWNED;
  assign out_valid = owned & req[sel_q];
  assign accept    = out_valid & out_ready;
  assign ack       = (accept & ~rst) ? (NUM_REQ'(1) << sel_q) : '0;
  assign timed_out = owned & (cnt_q == 8'(IDLE_TIMEOUT));
  assign release_w = timed_out | (accept & last[sel_q]);
  assign take      = (~owned | release_w) & found;
  assign drop      = release_w & ~found;

  always_comb begin
    state_d = take ? ST_OWNED : (drop ? ST_IDLE : state_q);
    sel_d   = take ? pick_idx : sel_q;
    gnt_d   = take ? (NUM_REQ'(1) << pick_idx) : (drop ? '0 : gnt_q);
    busy_d  = state_d == ST_OWNED;
    ptr_d   = release_w ? sel_q : ptr_q;
    cnt_d   = (~owned | release_w | req[sel_q]) ? 8'd0 : cnt_q + 8'd1;
    // timeout_err is high during exactly the cycle in which the count sits at the limit
    tmo_d   = cnt_d == 8'(IDLE_TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '1;
      ptr_q   <= '1;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign sel         = sel_q;
  assign gnt         = gnt_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_q;
endmodule

// File: tb/tb_mux16_arbiter.sv
// tb_mux16_arbiter: directed checks plus a per-cycle behavioural model of mux16_arbiter
module tb_mux16_arbiter;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic [15:0] last = '0;
  logic        out_ready = 1'b0;
  logic [3:0]  sel;
  logic [15:0] gnt, ack;
  logic        out_valid, busy, timeout_err;

  int n_chk = 0;
  int n_fail = 0;

  mux16_arbiter #(.NUM_REQ(16), .IDLE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .out_ready(out_ready),
    .sel(sel), .gnt(gnt), .out_valid(out_valid), .ack(ack), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner as an integer (-1 = nobody), last released owner, idle-cycle count.
  int m_owner = -1;
  int m_ptr = 15;
  int m_sel = 15;
  int m_cnt = 0;
  bit m_started = 0;

  function automatic int search(input int start, input logic [15:0] r);
    for (int i = 1; i <= 16; i++) if (r[(start + i) % 16]) return (start + i) % 16;
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    bit rel;
    if (rst) begin
      m_owner <= -1; m_ptr <= 15; m_sel <= 15; m_cnt <= 0; m_started <= 1;
    end else if (m_started) begin
      if (m_owner < 0) begin
        w = search(m_ptr, req);
        if (w >= 0) begin m_owner <= w; m_sel <= w; end
      end else begin
        rel = (m_cnt == TMO) || (req[m_owner] && out_ready && last[m_owner]);
        if (rel) begin
          w = search(m_owner, req);
          m_ptr <= m_owner; m_cnt <= 0; m_owner <= w;
          if (w >= 0) m_sel <= w;
        end else m_cnt <= req[m_owner] ? 0 : m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] e_gnt, e_ack;
    logic e_ov;
    if (m_started) begin
      e_gnt = (m_owner >= 0) ? 16'(1 << m_owner) : 16'h0;
      e_ov  = (m_owner >= 0) && req[m_owner];
      e_ack = (e_ov && out_ready && !rst) ? e_gnt : 16'h0;
      check("model sel", 32'(sel), 32'(m_sel));
      check("model gnt", 32'(gnt), 32'(e_gnt));
      check("model busy", 32'(busy), 32'(m_owner >= 0));
      check("model out_valid", 32'(out_valid), 32'(e_ov));
      check("model ack", 32'(ack), 32'(e_ack));
      check("model timeout_err", 32'(timeout_err), 32'((m_owner >= 0) && (m_cnt == TMO)));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1; req = '0; last = '0; out_ready = 0;
    tick; tick;
    rst = 0;
  endtask

  initial begin
    do_reset;
    check("reset sel", 32'(sel), 32'hF);
    check("reset gnt", 32'(gnt), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset timeout_err", 32'(timeout_err), 32'h0);

    req = 16'h0005; last = 16'hFFFF; out_ready = 1;
    tick; #1;
    check("rr c1 sel", 32'(sel), 32'h0);
    check("rr c1 ack", 32'(ack), 32'h0001);
    tick;
    check("rr c2 sel", 32'(sel), 32'h2);
    check("rr c2 busy", 32'(busy), 32'h1);
    tick;
    check("rr c3 sel", 32'(sel), 32'h0);
    req = 16'h0001; #1;
    tick;
    check("solo rewin sel", 32'(sel), 32'h0);
    check("solo rewin gnt", 32'(gnt), 32'h0001);

    do_reset;
    req = 16'h0088; last = 16'h0; out_ready = 1;
    tick;
    for (int b = 1; b <= 4; b++) begin
      if (b == 4) last = 16'h0008;
      #1;
      check("burst sel", 32'(sel), 32'h3);
      check("burst ack", 32'(ack), 32'h0008);
      tick;
    end
    check("burst handoff sel", 32'(sel), 32'h7);

    do_reset;
    req = 16'h0020; out_ready = 0;
    tick;
    for (int i = 0; i < 10; i++) begin
      check("stall sel", 32'(sel), 32'h5);
      check("stall gnt", 32'(gnt), 32'h0020);
      check("stall ack", 32'(ack), 32'h0);
      tick;
    end

    do_reset;
    req = 16'h0200; out_ready = 0;
    tick;
    check("wd owner sel", 32'(sel), 32'h9);
    req = 16'h0002; #1;
    for (int i = 0; i < 16; i++) begin
      check("wd quiet", 32'(timeout_err), 32'h0);
      tick;
    end
    check("wd pulse", 32'(timeout_err), 32'h1);
    tick;
    check("wd handoff sel", 32'(sel), 32'h1);
    check("wd pulse gone", 32'(timeout_err), 32'h0);

    do_reset;
    req = 16'h0200;
    tick;
    req = 16'h0; #1;
    for (int i = 0; i < 16; i++) tick;
    check("wd idle pulse", 32'(timeout_err), 32'h1);
    tick;
    check("wd idle busy", 32'(busy), 32'h0);
    check("wd idle ptr", 32'(sel), 32'h9);

    do_reset;
    req = 16'h8001; last = 16'hFFFF; out_ready = 1;
    tick;
    check("wrap first", 32'(sel), 32'h0);
    tick;
    check("wrap second", 32'(sel), 32'hF);
    tick;
    check("wrap third", 32'(sel), 32'h0);

    do_reset;
    req = 16'h0010; last = 16'h0; out_ready = 1;
    tick; tick;
    check("mid burst ack", 32'(ack), 32'h0010);
    rst = 1; #1;
    check("reset cycle ack", 32'(ack), 32'h0);
    tick;
    check("mid rst gnt", 32'(gnt), 32'h0);
    check("mid rst busy", 32'(busy), 32'h0);
    check("mid rst sel", 32'(sel), 32'hF);
    rst = 0;
    tick; tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
